// File: rtl/mcpu_dc_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter
// and the L1 data-cache controller.
interface mcpu_dc_arbiter_if;
    logic        req0_valid;
    logic [29:0] req0_paddr;
    logic [3:0]  req0_write;
    logic [31:0] req0_wdata;
    logic        req0_done;
    logic [31:0] req0_rdata;

    logic        req1_valid;
    logic [29:0] req1_paddr;
    logic [3:0]  req1_write;
    logic [31:0] req1_wdata;
    logic        req1_done;
    logic [31:0] req1_rdata;

    logic        arb2dc_valid;
    logic [29:0] arb2dc_paddr;
    logic [3:0]  arb2dc_write;
    logic [31:0] arb2dc_wdata;
    logic        dc2arb_done;
    logic [31:0] dc2arb_rdata;
    logic        arb_owner;

    modport slave (
        input  req0_valid, req0_paddr, req0_write, req0_wdata,
        input  req1_valid, req1_paddr, req1_write, req1_wdata,
        output req0_done, req0_rdata, req1_done, req1_rdata,
        output arb2dc_valid, arb2dc_paddr, arb2dc_write,
        output arb2dc_wdata, arb_owner,
        input  dc2arb_done, dc2arb_rdata
    );

    modport master (
        output req0_valid, req0_paddr, req0_write, req0_wdata,
        output req1_valid, req1_paddr, req1_write, req1_wdata,
        input  req0_done, req0_rdata, req1_done, req1_rdata,
        input  arb2dc_valid, arb2dc_paddr, arb2dc_write,
        input  arb2dc_wdata, arb_owner,
        output dc2arb_done, dc2arb_rdata
    );
endinterface

// File: rtl/mcpu_dc_arbiter.sv
// Round-robin two-port arbiter in front of the L1 data cache.
// Grants hold until the cache completes; every output is a flop.
module mcpu_dc_arbiter #(
    parameter int P0_FIRST = 1
) (
    input logic             clkrst_core_clk,
    input logic             clkrst_core_rst,
    mcpu_dc_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic LAST_RST = (P0_FIRST != 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic        owner_q, owner_d;
    logic [29:0] paddr_q, paddr_d;
    logic [3:0]  write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic elig0, elig1, gnt_any, gnt_sel;

    // A port whose done is high this cycle has not yet dropped valid.
    assign elig0   = bus.req0_valid & ~done0_q;
    assign elig1   = bus.req1_valid & ~done1_q;
    assign gnt_any = elig0 | elig1;
    assign gnt_sel = (elig0 & elig1) ? ~last_q : elig1;

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            valid_q  <= 1'b0;
            owner_q  <= 1'b0;
            paddr_q  <= '0;
            write_q  <= '0;
            wdata_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            paddr_q  <= paddr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        valid_d  = valid_q;
        owner_d  = owner_q;
        paddr_d  = paddr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = BUSY;
                    valid_d = 1'b1;
                    owner_d = gnt_sel;
                    last_d  = gnt_sel;
                    paddr_d = gnt_sel ? bus.req1_paddr : bus.req0_paddr;
                    write_d = gnt_sel ? bus.req1_write : bus.req0_write;
                    wdata_d = gnt_sel ? bus.req1_wdata : bus.req0_wdata;
                end
            end
            BUSY: begin
                if (bus.dc2arb_done) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    if (owner_q) begin
                        done1_d  = 1'b1;
                        rdata1_d = bus.dc2arb_rdata;
                    end else begin
                        done0_d  = 1'b1;
                        rdata0_d = bus.dc2arb_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.arb2dc_valid = valid_q;
    assign bus.arb2dc_paddr = paddr_q;
    assign bus.arb2dc_write = write_q;
    assign bus.arb2dc_wdata = wdata_q;
    assign bus.arb_owner    = owner_q;
    assign bus.req0_done    = done0_q;
    assign bus.req1_done    = done1_q;
    assign bus.req0_rdata   = rdata0_q;
    assign bus.req1_rdata   = rdata1_q;
endmodule

// File: doc/mcpu_dc_arbiter.md
# mcpu_dc_arbiter

Two-port arbiter sharing the single data-cache request bus (30-bit word address, 4-bit byte-write mask, 32-bit write/read data, valid/done handshake) between the memory stage (port 0) and a second requester (port 1: instruction-fetch refill or debug access).
- Grants are round-robin. A grant holds until the cache returns done.
- Downstream signals are registered. Each requester sees a one-cycle done pulse carrying registered read data.
- Sits between the core pipeline and the L1 data-cache controller.

## Interface
Parameters:
- P0_FIRST, default 1: after reset, the first contended grant goes to port 0 (1) or to port 1 (0).

Ports:
- clkrst_core_clk  in  1  core clock; all state updates on its rising edge
- clkrst_core_rst  in  1  reset, synchronous, active-high
- req0_valid, req1_valid  in  1 each  request pending; held high with fields stable until that port's done
- req0_paddr, req1_paddr  in  30 each  word address
- req0_write, req1_write  in  4 each  byte-write mask; 0 = read
- req0_wdata, req1_wdata  in  32 each  write data
- req0_done, req1_done  out  1 each  one-cycle completion pulse
- req0_rdata, req1_rdata  out  32 each  read data, valid only while the matching done is high
- arb2dc_valid  out  1  downstream request valid
- arb2dc_paddr  out  30  latched address
- arb2dc_write  out  4  latched mask
- arb2dc_wdata  out  32  latched write data
- dc2arb_done  in  1  cache completion; sampled only while arb2dc_valid is high
- dc2arb_rdata  in  32  read data, valid with dc2arb_done
- arb_owner  out  1  port currently granted; meaningful only while arb2dc_valid is high

## Operation
- Reset values: all outputs 0; state IDLE; last-grant pointer set so the next contended grant follows P0_FIRST.
- States: IDLE and BUSY.
- Request eligibility:
  - A port is eligible when its valid is high and its done is not asserted this cycle.
  - The masking prevents re-granting a requester that has not yet dropped valid after its done.
- IDLE transitions:
  - One eligible port: grant it.
  - Both eligible: grant the port not granted last.
  - On a grant, latch that port's paddr/write/wdata into the arb2dc registers, set arb2dc_valid=1 and arb_owner, update the last-grant pointer, and go to BUSY.
  - No eligible port: stay in IDLE.
- BUSY transitions:
  - Hold all arb2dc outputs constant.
  - On dc2arb_done=1: register dc2arb_rdata into the owner's rdata, pulse the owner's done next cycle, clear arb2dc_valid, and go to IDLE.
- Non-owner rdata holds its last value. Its done stays 0.
- Requests are never dropped or duplicated. Each accepted request produces exactly one done.
- Requester changes to fields while valid is high are ignored after the grant, because the latched copy is used.
- Reset mid-transaction:
  - Next cycle: arb2dc_valid=0, both done=0, state IDLE, pointer reinitialised.
  - The cache must tolerate an abandoned request.
  - A dc2arb_done arriving in the reset cycle is ignored.
- dc2arb_done while arb2dc_valid is low: ignored, no state change.

## Timing
- Grant latency: eligible valid sampled in IDLE at cycle N → arb2dc_valid=1 at N+1.
- Completion latency: dc2arb_done=1 at cycle M → reqX_done=1 and arb2dc_valid=0 at M+1.
- Done width: done is high for exactly one cycle.
- Back-to-back turnaround:
  - At M+1 the other port may be granted, giving arb2dc_valid=1 at M+2.
  - The same port cannot be re-granted until M+2 (arb2dc_valid at M+3), because its done masks it at M+1.
- Zero-wait cache: dc2arb_done in the first cycle of valid gives a minimum of 2 cycles from request to done.
- Throughput: one downstream request per 2 cycles with a zero-wait cache.
- Combinational paths: none from inputs to outputs. All outputs are flops.

## Test plan
- Reset sequence:
  - Stimulus: assert clkrst_core_rst for 2 cycles with both valids high.
  - Required response: all outputs 0 throughout reset. The first grant after reset goes to port 0 (P0_FIRST=1), with arb2dc_valid=1 in the cycle after reset is released.
- Single read:
  - Stimulus: port 0 read, paddr=30'h0000_1234, write=0; cache returns done after 3 cycles with rdata=32'hDEAD_BEEF.
  - Required response: req0_done is high for one cycle with req0_rdata=32'hDEAD_BEEF. req1_done stays 0.
- Contention:
  - Stimulus: both ports hold valid continuously, zero-wait cache.
  - Required response: arb_owner alternates 0,1,0,1. Each done occurs exactly once per grant. Each grant forwards that port's paddr/write/wdata unchanged, e.g. port 1 write=4'b0011, wdata=32'h0000_ABCD.
- Sticky requester:
  - Stimulus: port 0 keeps valid high for one cycle after its done; port 1 is idle.
  - Required response: no second grant at M+1. Re-grant occurs at M+2 only if valid is still high.
- Field change after grant:
  - Stimulus: port 1 changes paddr while in BUSY.
  - Required response: arb2dc_paddr remains at the latched value until done.
- Reset mid-transaction:
  - Stimulus: assert reset while BUSY with dc2arb_done=1 in the same cycle.
  - Required response: no done pulse. arb2dc_valid=0 on the next cycle.
